// File: rtl/mdu_unit_pkg.sv
// Shared MDU constants: op encodings, default cycle counts and FSM state codes.
package mdu_unit_pkg;

  localparam logic [2:0] MDU_NONE  = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  localparam int MDU_MULT_CYC = 5;
  localparam int MDU_DIV_CYC  = 10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic logic is_mdu_arith(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_unit_arith.sv
// Combinational multiply/divide datapath; the FSM latches whatever this produces.
module mdu_arith
  import mdu_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero
);

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   b_safe;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;

  // Sign-extended operands multiplied modulo 2^(2W) give the signed product.
  assign prod_s = {{WIDTH{rs[WIDTH-1]}}, rs} * {{WIDTH{rt[WIDTH-1]}}, rt};
  assign prod_u = {{WIDTH{1'b0}}, rs} * {{WIDTH{1'b0}}, rt};

  // Signed divide runs on magnitudes so MIN/-1 wraps to MIN without relying on
  // the simulator's handling of signed overflow.
  assign neg_a  = (op == MDU_DIV) & rs[WIDTH-1];
  assign neg_b  = (op == MDU_DIV) & rt[WIDTH-1];
  assign a_mag  = neg_a ? (~rs + 1'b1) : rs;
  assign b_mag  = neg_b ? (~rt + 1'b1) : rt;
  assign b_safe = (b_mag == '0) ? WIDTH'(1) : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;

  always_comb begin
    res_hi   = '0;
    res_lo   = '0;
    div_zero = 1'b0;
    case (op)
      MDU_MULT: begin
        res_hi = prod_s[2*WIDTH-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
      end
      MDU_MULTU: begin
        res_hi = prod_u[2*WIDTH-1:WIDTH];
        res_lo = prod_u[WIDTH-1:0];
      end
      MDU_DIV, MDU_DIVU: begin
        div_zero = (rt == '0);
        res_lo   = (neg_a ^ neg_b) ? (~q_mag + 1'b1) : q_mag;
        res_hi   = neg_a ? (~r_mag + 1'b1) : r_mag;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// EX-stage multi-cycle MDU: owns HI/LO, holds a latched result for a fixed
// number of cycles and commits it on the edge where busy falls.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MDU_MULT_CYC,
  parameter int DIV_CYCLES  = MDU_DIV_CYC
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       mdu_op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [0:0]       state_q,   state_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
  logic             pend_wr_q, pend_wr_d;
  logic [WIDTH-1:0] hi_q,      hi_d;
  logic [WIDTH-1:0] lo_q,      lo_d;

  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             div_zero;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op       (mdu_op),
    .rs       (rs_data),
    .rt       (rt_data),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_mdu_arith(mdu_op)) begin
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            // A zero divisor still occupies the unit but never commits.
            pend_wr_d = ~div_zero;
            cnt_d     = ((mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU)) ?
                        CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            state_d   = ST_RUN;
          end else if (mdu_op == MDU_MTHI) begin
            hi_d = rs_data;
          end else if (mdu_op == MDU_MTLO) begin
            lo_d = rs_data;
          end
        end
      end
      ST_RUN: begin
        if (cnt_q == CW'(1)) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          cnt_d     = '0;
          pend_wr_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: hand-computed HI/LO results, busy timing,
// MT writes, divide-by-zero, start-while-busy and mid-operation reset.
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int sbw_cnt = 0;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .mdu_op  (mdu_op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The hazard unit should never let this happen; note it when it does.
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(start && busy)) else begin
        sbw_cnt++;
        $warning("start-while-busy seen, op=%0d", mdu_op);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge following the sampling edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start   = 1'b1;
    mdu_op  = op;
    rs_data = a;
    rt_data = b;
    @(negedge clk);
    start   = 1'b0;
    mdu_op  = MDU_NONE;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int cycles,
                        input logic [31:0] new_hi, input logic [31:0] new_lo);
    issue(op, a, b);
    for (int i = 0; i < cycles; i++) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_hi_hold"}, hi, exp_hi);
      check({tag, "_lo_hold"}, lo, exp_lo);
      if (i < cycles - 1) @(negedge clk);
    end
    @(negedge clk);
    exp_hi = new_hi;
    exp_lo = new_lo;
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    mdu_op  = MDU_NONE;
    rs_data = '0;
    rt_data = '0;
    exp_hi  = '0;
    exp_lo  = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    reset_n = 1'b1;

    run_op("mult_neg",  MDU_MULT,  32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu_max", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001);
    run_op("div_neg",   MDU_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_negrt", MDU_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
    run_op("divu",      MDU_DIVU,  32'd7,        32'd2,        10, 32'h00000001, 32'h00000003);
    run_op("div_ovf",   MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);

    issue(MDU_MTHI, 32'h12345678, 32'h0);
    exp_hi = 32'h12345678;
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_hi", hi, exp_hi);
    check("mthi_lo", lo, exp_lo);
    issue(MDU_MTLO, 32'h9ABCDEF0, 32'h0);
    exp_lo = 32'h9ABCDEF0;
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    check("mtlo_hi", hi, exp_hi);
    check("mtlo_lo", lo, exp_lo);

    run_op("divu_zero", MDU_DIVU, 32'd5, 32'd0, 10, 32'h12345678, 32'h9ABCDEF0);

    // MULT with an MTLO sneaking in during RUN cycle 2.
    issue(MDU_MULT, 32'h10, 32'h20);
    check("sbw_busy1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start   = 1'b1;
    mdu_op  = MDU_MTLO;
    rs_data = 32'hDEADBEEF;
    @(negedge clk);
    start   = 1'b0;
    mdu_op  = MDU_NONE;
    check("sbw_busy3", {31'd0, busy}, 32'd1);
    check("sbw_lo_hold", lo, 32'h9ABCDEF0);
    repeat (3) @(negedge clk);
    check("sbw_busy_done", {31'd0, busy}, 32'd0);
    check("sbw_hi", hi, 32'h0);
    check("sbw_lo", lo, 32'h200);
    check("sbw_flagged", sbw_cnt, 32'd1);
    exp_hi = 32'h0;
    exp_lo = 32'h200;

    issue(MDU_NONE, 32'h11111111, 32'h2);
    check("none_busy", {31'd0, busy}, 32'd0);
    check("none_hi", hi, exp_hi);
    check("none_lo", lo, exp_lo);
    issue(3'd7, 32'h22222222, 32'h3);
    check("rsvd_busy", {31'd0, busy}, 32'd0);
    check("rsvd_hi", hi, exp_hi);
    check("rsvd_lo", lo, exp_lo);

    issue(MDU_MTHI, 32'hA5A5A5A5, 32'h0);
    check("mthi2_hi", hi, 32'hA5A5A5A5);

    // Asynchronous reset in DIV cycle 4 must clear everything before the next edge.
    issue(MDU_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    check("rst_pre_busy", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_hi = 32'h0;
    exp_lo = 32'h0;

    run_op("mult_post_rst", MDU_MULT, 32'd2, 32'd3, 5, 32'h0, 32'h6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
